ysyx_25020047_ifu: RTL and testbench
====================================

// Module: ysyx_25020047_ifu
// PURPOSE
//  Instruction fetch unit. Consumes the next-PC (dnpc) produced by the writeback stage at the end of each instruction.
//  Holds the architectural PC, fetches one instruction from instruction memory over a valid/ready request/response
//  interface, and presents {inst, pc, snpc} downstream to decode with a valid/ready handshake.
//  Multi-cycle core: exactly one instruction is in flight at any time.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset; first fetch address
//  PC_STEP    32'd4          snpc increment (pc + PC_STEP)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   synchronous, active-high reset
//  wb_valid        in   1   writeback presents a valid dnpc
//  wb_dnpc         in   32  next PC from writeback
//  wb_ready        out  1   IFU accepts dnpc (high only in IDLE)
//  imem_req_valid  out  1   fetch request valid
//  imem_req_addr   out  32  fetch address (= pc)
//  imem_req_ready  in   1   memory accepts request
//  imem_rsp_valid  in   1   fetch response valid (always accepted in WAIT)
//  imem_rsp_data   in   32  fetched instruction word
//  out_valid       out  1   {out_inst,out_pc,out_snpc} valid to decode
//  out_ready       in   1   decode accepts
//  out_inst        out  32  instruction word
//  out_pc          out  32  PC of out_inst
//  out_snpc        out  32  out_pc + PC_STEP, modulo 2^32
// BEHAVIOUR
//  States: REQ, WAIT, HOLD, IDLE. One-hot or binary is implementer's choice; no other states.
//  Reset: state=REQ, pc=RESET_PC, out_inst=0, out_valid=0, wb_ready=0. In the reset cycle, imem_req_valid=0.
//   imem_req_valid rises in the first cycle after rst deasserts.
//  REQ:  imem_req_valid=1, imem_req_addr=pc (stable while waiting). On imem_req_ready -> WAIT.
//  WAIT: imem_req_valid=0. On imem_rsp_valid: out_inst<=imem_rsp_data -> HOLD. Same-cycle req-ready+rsp not possible (rsp
//        is only sampled in WAIT); a response in REQ/HOLD/IDLE is ignored.
//  HOLD: out_valid=1; out_inst/out_pc/out_snpc stable. On out_ready -> IDLE (out_valid low next cycle).
//  IDLE: wb_ready=1. On wb_valid: pc<=wb_dnpc -> REQ. wb_dnpc is not checked against out_snpc (branch or not, same path).
//  Outputs are registered or derived from state plus registers only; no combinational path from any input to any output.
//  Latency:
//   - wb handshake to imem_req_valid: 1 cycle.
//   - rsp to out_valid: 1 cycle.
//   - min loop wb->wb: 4 cycles with memory ready in 0 cycles.
//  out_snpc: pc+PC_STEP truncated to 32 bits; pc=32'hFFFF_FFFC gives snpc=32'h0000_0000.
//  wb_valid outside IDLE: ignored; writeback must hold until wb_ready. out_ready outside HOLD: ignored.
//  Reset mid-operation: any state -> REQ with pc=RESET_PC. An outstanding request is abandoned.
//   Instruction memory shares rst, so no stale response returns.
//  pc changes only on reset or the IDLE wb handshake.
// CONFIGURATION
//  YSYX_25020047_IFU_MISALIGN_CHECK_EN
//  Defined:
//   - adds output port fetch_fault (1b, reset 0).
//   - In REQ, if pc[1:0]!=0: no request is issued (imem_req_valid=0); fetch_fault=1, out_inst=32'h0, -> HOLD.
//   - fetch_fault is held with out_valid and clears on the out_ready handshake.
//  Undefined: no fetch_fault port; pc[1:0] is not examined and the address is issued as-is.
// TESTING
//  1. Reset, req_ready=1, rsp 1 cycle later with data 32'h00100093 -> req_addr=0x80000000; out_inst=0x00100093,
//     out_pc=0x80000000, out_snpc=0x80000004.
//  2. Sequential loop: wb_dnpc=out_snpc for 3 instructions -> req_addr 0x80000004, 0x80000008, 0x8000000C in order;
//     wb_ready only in IDLE.
//  3. Backpressure: req_ready low 5 cycles, out_ready low 3 cycles -> req_addr and out_* stable; one request, one
//     output per instruction.
//  4. Wrap: wb_dnpc=0xFFFFFFFC -> out_pc=0xFFFFFFFC, out_snpc=0x00000000.
//  5. rst pulsed in WAIT, then late rsp_valid ignored in REQ -> next req_addr=0x80000000, out_valid stays 0 until the new rsp.
//  6. With MISALIGN_CHECK_EN: wb_dnpc=0x80000002 -> imem_req_valid never asserts; out_valid=1, fetch_fault=1,
//     out_inst=0. Without the macro, req_addr=0x80000002 is issued.

Source files
------------

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: holds the PC, does one imem request/response per instruction and presents {inst,pc,snpc} to decode.
// Optional YSYX_25020047_IFU_MISALIGN_CHECK_EN: flag misaligned PCs with fetch_fault instead of issuing them.
module ysyx_25020047_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [31:0] wb_dnpc,
  output logic        wb_ready,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_snpc
`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_IDLE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        req_arm;
  logic        misalign;

`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (misalign)                     state_nxt = S_HOLD;
        else if (req_arm && imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT:  if (imem_rsp_valid) state_nxt = S_HOLD;
      S_HOLD:  if (out_ready)      state_nxt = S_IDLE;
      S_IDLE:  if (wb_valid)       state_nxt = S_REQ;
      default:                     state_nxt = S_REQ;
    endcase
  end

  // req_arm keeps the request low for the first cycle out of reset, without a path from rst to the output
  always_comb begin
    imem_req_valid = (state == S_REQ) && req_arm && !misalign;
    out_valid      = (state == S_HOLD);
    wb_ready       = (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      out_inst <= '0;
      req_arm  <= 1'b0;
    end else begin
      req_arm <= 1'b1;
      if (state == S_IDLE && wb_valid)       pc       <= wb_dnpc;
      if (state == S_WAIT && imem_rsp_valid) out_inst <= imem_rsp_data;
      if (state == S_REQ && misalign)        out_inst <= '0;
    end
  end

`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                fetch_fault <= 1'b0;
    else if (state == S_REQ && misalign)    fetch_fault <= 1'b1;
    else if (state == S_HOLD && out_ready)  fetch_fault <= 1'b0;
  end
`endif

  assign imem_req_addr = pc;
  assign out_pc        = pc;
  assign out_snpc      = pc + PC_STEP;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Randomized bench for ysyx_25020047_ifu: memory/decode/writeback agents plus a transaction-level model checked every cycle.
module tb_ysyx_25020047_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid, wb_ready, imem_req_valid, imem_req_ready, imem_rsp_valid, out_valid, out_ready;
  logic [31:0] wb_dnpc, imem_req_addr, imem_rsp_data, out_inst, out_pc, out_snpc;
`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  ysyx_25020047_ifu dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_dnpc(wb_dnpc), .wb_ready(wb_ready),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_snpc(out_snpc)
`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Agent knobs
  int          p_rdy = 100, p_ordy = 100, p_spur = 0, p_junk = 0, min_dly = 0, max_dly = 0;
  int          dnpc_mode = 0;  // 0: sequential, 1: mix of sequential and random jumps, 2: fixed_dnpc
  bit          wb_en = 1'b1, use_fixed_data = 1'b1;
  logic [31:0] fixed_dnpc = 32'h0, fixed_data = 32'h0010_0093;
  int          n_req = 0, n_out = 0, n_wb = 0;
  logic [31:0] addr_log[$];

  // Memory, decode and writeback agents
  initial begin : engine
    bit outst, need_wb, wb_up, rsp_real;
    int dly, wdly;
    logic [31:0] dnpc_q;
    outst = 0; need_wb = 0; wb_up = 0; rsp_real = 0; dly = 0; wdly = 0; dnpc_q = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; out_ready = 0; wb_valid = 0; wb_dnpc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outst = 0; need_wb = 0; wb_up = 0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          outst = 1; dly = $urandom_range(max_dly, min_dly); n_req++;
          addr_log.push_back(imem_req_addr);
        end else if (outst && rsp_real) outst = 0;
        if (out_valid && out_ready) begin
          n_out++; need_wb = 1; wb_up = 0; wdly = $urandom_range(max_dly, min_dly);
        end
        if (wb_valid && wb_ready) begin n_wb++; need_wb = 0; wb_up = 0; end
      end
      @(posedge clk); #1;
      imem_req_ready = ($urandom_range(99, 0) < p_rdy);
      rsp_real = 0;
      if (outst) begin
        if (dly == 0) begin
          imem_rsp_valid = 1; imem_rsp_data = use_fixed_data ? fixed_data : $urandom; rsp_real = 1;
        end else begin
          dly--; imem_rsp_valid = 0;
        end
      end else begin
        imem_rsp_valid = ($urandom_range(99, 0) < p_spur); imem_rsp_data = $urandom;
      end
      out_ready = ($urandom_range(99, 0) < p_ordy);
      if (need_wb) begin
        if (!wb_en) wb_valid = 0;
        else if (wdly > 0) begin wdly--; wb_valid = 0; end
        else begin
          if (!wb_up) begin
            case (dnpc_mode)
              0:       dnpc_q = out_snpc;
              1:       dnpc_q = $urandom_range(1, 0) ? out_snpc : ($urandom & 32'hFFFF_FFFC);
              default: dnpc_q = fixed_dnpc;
            endcase
            wb_up = 1;
          end
          wb_valid = 1; wb_dnpc = dnpc_q;
        end
      end else begin
        wb_valid = ($urandom_range(99, 0) < p_junk); wb_dnpc = $urandom;
      end
    end
  end

  // Transaction-level model: where in the fetch/deliver/retire sequence the current instruction is
  bit          m_init = 0, m_bub = 0, m_req = 0, m_rsp = 0, m_out = 0, m_flt = 0;
  logic [31:0] m_pc = 32'h0, m_inst = 32'h0;

  always @(negedge clk) begin : cmp
    bit mis;
    mis = 0;
`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
    mis = (m_pc[1:0] != 2'b00);
`endif
    if (m_init) begin
      chk("imem_req_valid", imem_req_valid, !m_bub && !m_req && !mis);
      chk("imem_req_addr",  imem_req_addr,  m_pc);
      chk("out_valid",      out_valid,      m_rsp && !m_out);
      chk("wb_ready",       wb_ready,       m_out);
      chk("out_inst",       out_inst,       m_inst);
      chk("out_pc",         out_pc,         m_pc);
      chk("out_snpc",       out_snpc,       m_pc + 32'd4);
`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
      chk("fetch_fault",    fetch_fault,    m_flt);
`endif
    end
    if (rst) begin
      m_init = 1; m_bub = 1; m_req = 0; m_rsp = 0; m_out = 0; m_flt = 0;
      m_pc = 32'h8000_0000; m_inst = 32'h0;
    end else if (m_init) begin
      if (!m_req && mis) begin m_req = 1; m_rsp = 1; m_inst = 0; m_flt = 1; end
      else if (!m_req) begin if (!m_bub && imem_req_ready) m_req = 1; end
      else if (!m_rsp) begin if (imem_rsp_valid) begin m_rsp = 1; m_inst = imem_rsp_data; end end
      else if (!m_out) begin if (out_ready) begin m_out = 1; m_flt = 0; end end
      else if (wb_valid) begin m_req = 0; m_rsp = 0; m_out = 0; m_pc = wb_dnpc; end
      m_bub = 0;
    end
  end

  // kind: 0 out_valid, 1 wb_ready, 2 imem_req_valid, 3 n_wb>=target, 4 n_req>=target, 5 addr_log size>=target
  task automatic wait_cond(input string nm, input int kind, input int target, input int bound);
    bit ok;
    ok = 0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk); #2;
      case (kind)
        0:       ok = (out_valid === 1'b1);
        1:       ok = (wb_ready === 1'b1);
        2:       ok = (imem_req_valid === 1'b1);
        3:       ok = (n_wb >= target);
        4:       ok = (n_req >= target);
        default: ok = (addr_log.size() >= target);
      endcase
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait %s: not reached within %0d cycles", nm, bound);
    end
  endtask

  initial begin : seq
    int b_req, b_out, b_wb, b_log;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset imem_req_valid", imem_req_valid, 1'b0);
    chk("reset out_valid",      out_valid,      1'b0);
    chk("reset wb_ready",       wb_ready,       1'b0);
    chk("reset out_inst",       out_inst,       32'h0);
    chk("reset out_pc",         out_pc,         32'h8000_0000);
    @(posedge clk); #1;
    chk("first req_valid", imem_req_valid, 1'b1);
    chk("first req_addr",  imem_req_addr,  32'h8000_0000);

    // First fetch
    wait_cond("t1 out_valid", 0, 0, 50);
    chk("t1 out_inst", out_inst, 32'h0010_0093);
    chk("t1 out_pc",   out_pc,   32'h8000_0000);
    chk("t1 out_snpc", out_snpc, 32'h8000_0004);

    // Sequential loop
    use_fixed_data = 0;
    wait_cond("t2 three more requests", 5, 4, 100);
    if (addr_log.size() >= 4) begin
      chk("t2 addr0", addr_log[0], 32'h8000_0000);
      chk("t2 addr1", addr_log[1], 32'h8000_0004);
      chk("t2 addr2", addr_log[2], 32'h8000_0008);
      chk("t2 addr3", addr_log[3], 32'h8000_000C);
    end

    // Backpressure on both sides
    wb_en = 0;
    wait_cond("t3 idle", 1, 0, 100);
    p_rdy = 0; p_ordy = 0; b_req = n_req; b_out = n_out;
    wb_en = 1;
    wait_cond("t3 req_valid", 2, 0, 20);
    b_wb = n_wb;
    repeat (5) begin
      @(negedge clk); #2;
      chk("t3 req_valid held", imem_req_valid, 1'b1);
    end
    p_rdy = 100;
    wait_cond("t3 out_valid", 0, 0, 20);
    repeat (3) begin
      @(negedge clk); #2;
      chk("t3 out_valid held", out_valid, 1'b1);
    end
    p_ordy = 100;
    wait_cond("t3 retire", 3, b_wb + 1, 20);
    chk("t3 one request", n_req - b_req, 32'd1);
    chk("t3 one output",  n_out - b_out, 32'd1);

    // PC wrap
    wb_en = 0;
    wait_cond("t4 idle", 1, 0, 100);
    dnpc_mode = 2; fixed_dnpc = 32'hFFFF_FFFC; wb_en = 1;
    wait_cond("t4 out_valid", 0, 0, 50);
    chk("t4 out_pc",   out_pc,   32'hFFFF_FFFC);
    chk("t4 out_snpc", out_snpc, 32'h0000_0000);
    chk("t4 req_addr", addr_log[$], 32'hFFFF_FFFC);

    // Reset while waiting on memory, then a late response
    wb_en = 0;
    wait_cond("t5 idle", 1, 0, 100);
    dnpc_mode = 0; min_dly = 4; max_dly = 4; b_req = n_req; wb_en = 1;
    wait_cond("t5 request", 4, b_req + 1, 50);
    p_rdy = 0; p_spur = 100;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("t5 bubble req_valid", imem_req_valid, 1'b0);
    chk("t5 out_pc",           out_pc,         32'h8000_0000);
    repeat (3) begin
      @(negedge clk); #2;
      chk("t5 late rsp out_valid", out_valid, 1'b0);
    end
    chk("t5 req_valid", imem_req_valid, 1'b1);
    chk("t5 req_addr",  imem_req_addr,  32'h8000_0000);
    p_spur = 0; min_dly = 0; max_dly = 0; p_rdy = 100;
    wait_cond("t5 out_valid", 0, 0, 50);
    chk("t5 new out_pc", out_pc, 32'h8000_0000);

    // Misaligned target
    wb_en = 0;
    wait_cond("t6 idle", 1, 0, 100);
    dnpc_mode = 2; fixed_dnpc = 32'h8000_0002; b_req = n_req; b_log = addr_log.size();
    wb_en = 1;
`ifdef YSYX_25020047_IFU_MISALIGN_CHECK_EN
    wait_cond("t6 out_valid", 0, 0, 50);
    chk("t6 fetch_fault", fetch_fault,   1'b1);
    chk("t6 out_inst",    out_inst,      32'h0);
    chk("t6 out_pc",      out_pc,        32'h8000_0002);
    chk("t6 no request",  n_req - b_req, 32'd0);
`else
    wait_cond("t6 request", 5, b_log + 1, 50);
    if (addr_log.size() > b_log) chk("t6 req_addr", addr_log[b_log], 32'h8000_0002);
`endif
    dnpc_mode = 1;

    // Randomized traffic
    p_rdy = 60; p_ordy = 60; p_spur = 20; p_junk = 25; min_dly = 0; max_dly = 3;
    b_wb = n_wb;
    wait_cond("random retire", 3, b_wb + 60, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
